// File: rtl/and_gate_pkg.sv
// Shared defaults for the and_gate primitive and its observation stage.
// Pure constants; no logic, latency or flow control.
package and_gate_pkg;

    localparam int AND_DEF_WIDTH = 1;
    localparam int AND_DEF_CNT_W = 16;

endpackage : and_gate_pkg

// File: rtl/and_gate_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count reflects inc samples up to and including the previous edge.
// No backpressure: inc and clr are sampled every cycle; rst beats clr beats inc.
module sat_counter #(
    parameter int CNT_W = and_gate_pkg::AND_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/and_gate.sv
// Bitwise AND with a clocked observation stage (registered copy, rise pulse, high count).
// Latency: X combinational; X_Q, X_RISE and HIGH_CNT one cycle after the sampled inputs.
// No backpressure: every input is sampled on every rising edge.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_DEF_WIDTH,
    parameter int CNT_W = AND_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] X_Q,
    output logic [WIDTH-1:0] X_RISE,
    output logic [CNT_W-1:0] HIGH_CNT,
    input  logic             CNT_CLR
);

    logic [WIDTH-1:0] x_hist;

    // Kept free of clk/rst so it can sit anywhere in the datapath.
    assign X = A & B;

    // Clearing the history on reset makes the first high sample after reset pulse X_RISE.
    always_ff @(posedge clk) begin
        if (rst) begin
            X_Q    <= '0;
            X_RISE <= '0;
            x_hist <= '0;
        end else begin
            X_Q    <= X;
            X_RISE <= X & ~x_hist;
            x_hist <= X;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_high_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (CNT_CLR),
        .inc   (X[0]),
        .count (HIGH_CNT)
    );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: vector table, directed corner sequences, random vs model.
module tb_and_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;

    logic [3:0]  a4, b4, x4, xq4, xr4;
    logic [15:0] cnt16;
    logic [0:0]  a1, b1, x1, xq1, xr1;
    logic [2:0]  cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .X(x4), .X_Q(xq4),
        .X_RISE(xr4), .HIGH_CNT(cnt16), .CNT_CLR(clr)
    );

    and_gate #(.WIDTH(1), .CNT_W(3)) u_c3 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .X(x1), .X_Q(xq1),
        .X_RISE(xr1), .HIGH_CNT(cnt3), .CNT_CLR(clr)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] x;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        a4 = a;
        b4 = b;
        a1 = a[0];
        b1 = b[0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Reference model state, advanced once per edge.
    int unsigned m_cnt16, m_cnt3;
    logic [3:0]  m_prev4, m_q4, m_r4;
    logic        m_prev1, m_q1, m_r1;

    initial begin
        vec_t vecs[6];
        logic [3:0] xv;
        vecs[0] = '{4'b0000, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0001, 4'b0000, 4'b0000};
        vecs[2] = '{4'b0000, 4'b0001, 4'b0000};
        vecs[3] = '{4'b0001, 4'b0001, 4'b0001};
        vecs[4] = '{4'b1010, 4'b0110, 4'b0010};
        vecs[5] = '{4'b1111, 4'b0101, 4'b0101};

        rst = 1'b1;
        clr = 1'b0;
        drive(4'h0, 4'h0);

        // Combinational truth table, applied while reset is held.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].a, vecs[i].b);
            #10;
            xv = vecs[i].x;
            check($sformatf("tt_x4[%0d]", i), 32'(x4), 32'(xv));
            check($sformatf("tt_x1[%0d]", i), 32'(x1), 32'(xv[0]));
        end

        drive(4'h0, 4'h0);
        step();
        step();
        check("rst_xq4", 32'(xq4), 0);
        check("rst_xr4", 32'(xr4), 0);
        check("rst_cnt16", 32'(cnt16), 0);
        check("rst_cnt3", 32'(cnt3), 0);
        rst = 1'b0;

        // Four-bit registered copy.
        drive(4'b1010, 4'b0110);
        #1 check("w4_x", 32'(x4), 32'b0010);
        step();
        check("w4_xq", 32'(xq4), 32'b0010);

        // Edge pulse: one cycle high, then a second pulse after B drops and returns.
        drive(4'h0, 4'h0);
        do_reset();
        drive(4'h1, 4'h1);
        step();
        check("rise_c1", 32'(xr1), 1);
        step();
        check("rise_c2", 32'(xr1), 0);
        step();
        check("rise_c3", 32'(xr1), 0);
        drive(4'h1, 4'h0);
        step();
        check("rise_drop", 32'(xr1), 0);
        drive(4'h1, 4'h1);
        step();
        check("rise_again", 32'(xr1), 1);
        step();
        check("rise_again_end", 32'(xr1), 0);

        // Counter to 5, then saturation of the 3-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("cnt16_5", 32'(cnt16), 5);
        check("cnt3_5", 32'(cnt3), 5);
        for (int i = 0; i < 5; i++) step();
        check("cnt16_10", 32'(cnt16), 10);
        check("cnt3_sat", 32'(cnt3), 7);

        // Reset mid-run with the AND held high.
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("mid_cnt_pre", 32'(cnt16), 4);
        rst = 1'b1;
        #1 check("mid_x_pre", 32'(x1), 1);
        step();
        check("mid_xq", 32'(xq1), 0);
        check("mid_xr", 32'(xr1), 0);
        check("mid_cnt", 32'(cnt16), 0);
        check("mid_x", 32'(x1), 1);
        rst = 1'b0;
        step();
        check("mid_rise_after", 32'(xr1), 1);

        // Clear beats increment.
        step();
        clr = 1'b1;
        step();
        check("clr_cnt16", 32'(cnt16), 0);
        check("clr_cnt3", 32'(cnt3), 0);
        clr = 1'b0;
        step();
        check("clr_resume", 32'(cnt16), 1);

        // Randomized run against the model.
        do_reset();
        m_cnt16 = 0; m_cnt3 = 0;
        m_prev4 = '0; m_prev1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ra, rb, xe;
            logic       xe1;
            ra = 4'($urandom);
            rb = 4'($urandom);
            a4 = ra; b4 = rb;
            a1 = 1'($urandom); b1 = 1'($urandom);
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 39) == 0);
            #1;
            xe  = ra & rb;
            xe1 = a1[0] & b1[0];
            check("rnd_x4", 32'(x4), 32'(xe));
            check("rnd_x1", 32'(x1), 32'(xe1));
            if (rst) begin
                m_q4 = '0; m_r4 = '0; m_prev4 = '0;
                m_q1 = 1'b0; m_r1 = 1'b0; m_prev1 = 1'b0;
                m_cnt16 = 0; m_cnt3 = 0;
            end else begin
                m_r4 = xe & ~m_prev4;
                m_q4 = xe;
                m_prev4 = xe;
                m_r1 = xe1 & ~m_prev1;
                m_q1 = xe1;
                m_prev1 = xe1;
                if (clr) begin
                    m_cnt16 = 0;
                    m_cnt3 = 0;
                end else begin
                    if (xe[0] && m_cnt16 < 65535) m_cnt16++;
                    if (xe1 && m_cnt3 < 7) m_cnt3++;
                end
            end
            @(posedge clk);
            #1;
            check("rnd_xq4", 32'(xq4), 32'(m_q4));
            check("rnd_xr4", 32'(xr4), 32'(m_r4));
            check("rnd_cnt16", 32'(cnt16), m_cnt16);
            check("rnd_xq1", 32'(xq1), 32'(m_q1));
            check("rnd_xr1", 32'(xr1), 32'(m_r1));
            check("rnd_cnt3", 32'(cnt3), m_cnt3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_and_gate
